// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel valid/ready multiplexer with a single registered
// output stage. Mode 0 forwards one fixed channel; mode 1 arbitrates
// round-robin, starting the search one past the last granted channel.
// Optional feature macro: MUX_ARB_LOCK_EN adds a 'lock' input that keeps
// the round-robin grant on the last winner while it is still requesting.
module mux_arb_n #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      select,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
`ifdef MUX_ARB_LOCK_EN
    ,
    input  logic                 lock
`endif
);

    // Channel index k steps after p; wraps naturally because NCH is 2**SELW.
    function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] p, input int k);
        return p + k[SELW-1:0];
    endfunction

    logic [SELW-1:0] ptr_r;
    logic            load_s;
    logic            xfer_s;
    logic [SELW-1:0] rr_grant_s;
    logic            rr_vld_s;
    logic [SELW-1:0] grant_s;
    logic            grant_vld_s;
`ifdef MUX_ARB_LOCK_EN
    logic            lock_arm_r;
`endif

    assign load_s = ~out_valid | out_ready;
    assign xfer_s = ~rst & load_s & grant_vld_s;

    // Round-robin search: ptr+1, ptr+2, ... ending with ptr itself.
    always_comb begin
        rr_vld_s   = 1'b0;
        rr_grant_s = {SELW{1'b0}};
        for (int i = 1; i <= NCH; i++) begin
            if (!rr_vld_s && in_valid[rr_idx(ptr_r, i)]) begin
                rr_vld_s   = 1'b1;
                rr_grant_s = rr_idx(ptr_r, i);
            end else begin
                rr_vld_s   = rr_vld_s;
            end
        end
    end

    // Final grant: fixed select in mode 0, round-robin (optionally locked) in mode 1.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = {SELW{1'b0}};
        if (mode == 1'b0) begin
            if (in_valid[select]) begin
                grant_vld_s = 1'b1;
                grant_s     = select;
            end else begin
                grant_vld_s = 1'b0;
            end
        end else begin
`ifdef MUX_ARB_LOCK_EN
            if (lock && lock_arm_r && in_valid[ptr_r]) begin
                grant_vld_s = 1'b1;
                grant_s     = ptr_r;
            end else begin
                grant_vld_s = rr_vld_s;
                grant_s     = rr_grant_s;
            end
`else
            grant_vld_s = rr_vld_s;
            grant_s     = rr_grant_s;
`endif
        end
    end

    // One-hot accept towards the granted channel; silent during reset or backpressure.
    always_comb begin
        in_ready = {NCH{1'b0}};
        if (xfer_s) begin
            in_ready[grant_s] = 1'b1;
        end else begin
            in_ready = {NCH{1'b0}};
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= {WIDTH{1'b0}};
            out_sel   <= {SELW{1'b0}};
            ptr_r     <= SELW'(NCH - 1);
        end else if (xfer_s) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_s*WIDTH +: WIDTH];
            out_sel   <= grant_s;
            ptr_r     <= mode ? grant_s : ptr_r;
        end else if (load_s) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

`ifdef MUX_ARB_LOCK_EN
    // Lock only applies once a round-robin winner exists since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_arm_r <= 1'b0;
        end else if (xfer_s && mode) begin
            lock_arm_r <= 1'b1;
        end else begin
            lock_arm_r <= lock_arm_r;
        end
    end
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// Scoreboard bench for mux_arb_n (default 4 x 32-bit). Stimulus pushes the
// expected word whenever a transfer is expected; a monitor pops and compares
// each word the DUT hands downstream.
module tb_mux_arb_n;
    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 mode = 1'b0;
    logic [SELW-1:0]      select = 2'd0;
    logic [NCH-1:0]       in_valid = 4'b0000;
    logic [NCH*WIDTH-1:0] in_data = '0;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
    logic                 out_ready = 1'b1;
    logic                 lock = 1'b0;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int          kcyc   = 0;
    logic [WIDTH+SELW-1:0] expq[$];
    logic [WIDTH-1:0]      last_push = '0;

    mux_arb_n #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .select(select),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
`ifdef MUX_ARB_LOCK_EN
        , .lock(lock)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] wd(input int ch, input int k);
        return {4'(ch + 1), 12'h0AB, 16'(k)};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // One cycle of stimulus; exp_rdy / exp_ov are hand-computed.
    task automatic drive(input logic r, input logic m, input logic [1:0] s,
                         input logic [3:0] v, input logic ordy,
                         input logic [3:0] exp_rdy, input logic exp_ov);
        @(posedge clk);
        #1;
        kcyc++;
        rst = r; mode = m; select = s; in_valid = v; out_ready = ordy;
        for (int ch = 0; ch < NCH; ch++) in_data[ch*WIDTH +: WIDTH] = wd(ch, kcyc);
        if (r) expq.delete();
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (r) begin
            chk("rst_out_data", 64'(out_data), 64'd0);
            chk("rst_out_sel", 64'(out_sel), 64'd0);
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (exp_rdy[ch]) begin
                last_push = wd(ch, kcyc);
                expq.push_back({SELW'(ch), wd(ch, kcyc)});
            end
        end
    endtask

    // Monitor: every word consumed downstream must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_word", 64'(out_data), 64'hDEAD);
            end else begin
                logic [WIDTH+SELW-1:0] e;
                e = expq.pop_front();
                chk("out_sel", 64'(out_sel), 64'(e[WIDTH +: SELW]));
                chk("out_data", 64'(out_data), 64'(e[WIDTH-1:0]));
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] frozen;
        // Reset held with all channels requesting
        drive(1'b1, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0000, 1'b0);
        drive(1'b1, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0000, 1'b0);
        // Mode 0, select 2
        drive(1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b0);
        drive(1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1);
        drive(1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1);
        // Select 3 not requesting: no grant, output drains
        drive(1'b0, 1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b1);
        drive(1'b0, 1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0);
        // Mode 1, all requesting, ptr=3 from reset: 0,1,2,3,0
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1);
        // Mode 1, sparse requests 1010: 1,3,1,3
        drive(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1);
        // Backpressure: ptr=3 -> grant 0, then hold 3 cycles
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1);
        frozen = last_push;
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1);
            chk("frozen_sel", 64'(out_sel), 64'd0);
            chk("frozen_data", 64'(out_data), 64'(frozen));
        end
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1);
        // Reset mid-stream discards held word; restart from ptr=3
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1);
        drive(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0);
        drive(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0);
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1);
        // Drain
        drive(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);
`ifdef MUX_ARB_LOCK_EN
        drive(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0);
        lock = 1'b0;
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);
        lock = 1'b1;
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1);
        lock = 1'b0;
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b1);
        drive(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);
`endif
        drive(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);
        chk("scoreboard_empty", 64'(expq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
